// File: rtl/vector_write_back_queue_pkg.sv
// Shared VRF interface codes, write-back FSM states and the read-index hazard helper.
// Imported by the write-back queue, its storage sub-module and the testbench.
package vector_write_back_queue_pkg;

  localparam logic [1:0] RF_NOP          = 2'd0;
  localparam logic [1:0] VECTOR_RF_WRITE = 2'd2;
  localparam logic [1:0] RF_FINISHED     = 2'd3;

  localparam logic [2:0] ONE_BYTE   = 3'd0;
  localparam logic [2:0] TWO_BYTE   = 3'd1;
  localparam logic [2:0] FOUR_BYTE  = 3'd2;
  localparam logic [2:0] EIGHT_BYTE = 3'd3;

  typedef enum logic [1:0] {
    WBQ_IDLE  = 2'd0,
    WBQ_ISSUE = 2'd1,
    WBQ_WAIT  = 2'd2
  } wbq_state_e;

  // v0 only counts as a hit when decode is going to use it as the mask source.
  function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [4:0] rs3,
                                  input logic v0);
    return (rd == rs1) || (rd == rs2) || (rd == rs3) || (v0 && (rd == 5'd0));
  endfunction

endpackage

// File: rtl/vector_wb_fifo.sv
// Circular storage for pending VRF writes: payload plus destination register per entry.
// Exposes the head, full/empty and per-entry rd/valid so the parent can check hazards.
module vector_wb_fifo
  import vector_write_back_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        push,
  input  logic                        pop,
  input  logic [4:0]                  push_rd,
  input  logic [WIDTH-1:0]            push_data,
  output logic [4:0]                  head_rd,
  output logic [WIDTH-1:0]            head_data,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0][4:0]       entry_rd,
  output logic [DEPTH-1:0]            entry_valid
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0][4:0]       rd_q, rd_d;
  logic [AW-1:0]               rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]                 count_q, count_d;
  logic                        do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = en & push & ~full;
  assign do_pop    = en & pop & ~empty;
  assign head_rd   = rd_q[rptr_q];
  assign head_data = data_q[rptr_q];
  assign entry_rd  = rd_q;

  always_comb begin
    data_d  = data_q;
    rd_d    = rd_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (do_push) begin
      data_d[wptr_q] = push_data;
      rd_d[wptr_q]   = push_rd;
      wptr_d         = wptr_q + AW'(1);
    end
    if (do_pop) rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  // Slot i is live when its distance from the read pointer is below the fill count.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, AW'(i) - rptr_q} < count_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      rd_q    <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      rd_q    <= rd_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vector_write_back_queue.sv
// Queues vector results and drains them one at a time into the VRF write port,
// retiring each write on RF_FINISHED and flagging read-after-write hazards to decode.
//   state     | meaning
//   WBQ_IDLE  | nothing in flight; load the head as soon as the queue is non-empty
//   WBQ_ISSUE | write strobe and VECTOR_RF_WRITE asserted for this one cycle
//   WBQ_WAIT  | fields held, waiting for RF_FINISHED before the next issue
module vector_write_back_queue
  import vector_write_back_queue_pkg::*;
#(
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int DEPTH            = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4:0]                    in_rd,
  input  logic                          in_vm,
  input  logic [VECTOR_SIZE*LEN-1:0]    in_mask,
  input  logic [VECTOR_SIZE*LEN-1:0]    in_data,
  input  logic [ENTRY_INDEX_SIZE:0]     in_length,
  input  logic [2:0]                    in_data_type,
  output logic [1:0]                    rf_signal,
  output logic [4:0]                    rf_rd,
  output logic                          rf_vm,
  output logic [VECTOR_SIZE*LEN-1:0]    rf_mask,
  output logic [VECTOR_SIZE*LEN-1:0]    rf_data,
  output logic [ENTRY_INDEX_SIZE:0]     rf_length,
  output logic [2:0]                    rf_data_type,
  output logic                          write_back_enabled,
  input  logic [1:0]                    rf_status,
  input  logic [4:0]                    q_rs1,
  input  logic [4:0]                    q_rs2,
  input  logic [4:0]                    q_rs3,
  input  logic                          q_v0,
  output logic                          hazard,
  output logic                          empty
);
  localparam int VW = VECTOR_SIZE * LEN;
  localparam int LW = ENTRY_INDEX_SIZE + 1;
  localparam int PW = 1 + VW + VW + LW + 3;

  wbq_state_e             state_q, state_d;
  logic [1:0]             sig_q, sig_d;
  logic                   wbe_q, wbe_d;
  logic [4:0]             rd_q, rd_d;
  logic                   vm_q, vm_d;
  logic [VW-1:0]          mask_q, mask_d, data_q, data_d;
  logic [LW-1:0]          len_q, len_d;
  logic [2:0]             dt_q, dt_d;

  logic                   load;
  logic                   fifo_full, fifo_empty;
  logic [4:0]             head_rd;
  logic [PW-1:0]          head_data;
  logic [DEPTH-1:0][4:0]  entry_rd;
  logic [DEPTH-1:0]       entry_valid;

  vector_wb_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .en          (rdy_in),
    .push        (in_valid),
    .pop         (load),
    .push_rd     (in_rd),
    .push_data   ({in_vm, in_mask, in_data, in_length, in_data_type}),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  assign in_ready = ~fifo_full;
  assign empty    = fifo_empty && (state_q == WBQ_IDLE);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    wbe_d   = wbe_q;
    rd_d    = rd_q;
    vm_d    = vm_q;
    mask_d  = mask_q;
    data_d  = data_q;
    len_d   = len_q;
    dt_d    = dt_q;
    load    = 1'b0;
    if (rdy_in) begin
      wbe_d = 1'b0;
      sig_d = RF_NOP;
      unique case (state_q)
        WBQ_IDLE:  load = ~fifo_empty;
        WBQ_ISSUE: state_d = WBQ_WAIT;
        WBQ_WAIT: begin
          if (rf_status == RF_FINISHED) begin
            if (!fifo_empty) load = 1'b1;
            else             state_d = WBQ_IDLE;
          end
        end
        default:   state_d = WBQ_IDLE;
      endcase
      if (load) begin
        state_d = WBQ_ISSUE;
        wbe_d   = 1'b1;
        sig_d   = VECTOR_RF_WRITE;
        rd_d    = head_rd;
        {vm_d, mask_d, data_d, len_d, dt_d} = head_data;
      end
    end
  end

  // The in-flight write stays a hazard until it retires, even though it has left the queue.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && rd_hit(entry_rd[i], q_rs1, q_rs2, q_rs3, q_v0)) hazard = 1'b1;
    end
    if ((state_q != WBQ_IDLE) && rd_hit(rd_q, q_rs1, q_rs2, q_rs3, q_v0)) hazard = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WBQ_IDLE;
      sig_q   <= RF_NOP;
      wbe_q   <= 1'b0;
      rd_q    <= '0;
      vm_q    <= 1'b0;
      mask_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      dt_q    <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      wbe_q   <= wbe_d;
      rd_q    <= rd_d;
      vm_q    <= vm_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      len_q   <= len_d;
      dt_q    <= dt_d;
    end
  end

  assign rf_signal          = sig_q;
  assign write_back_enabled = wbe_q;
  assign rf_rd              = rd_q;
  assign rf_vm              = vm_q;
  assign rf_mask            = mask_q;
  assign rf_data            = data_q;
  assign rf_length          = len_q;
  assign rf_data_type       = dt_q;

endmodule

// File: tb/tb_vector_write_back_queue.sv
// Directed bench for vector_write_back_queue: reset, single write, fill/drain order,
// hazard detection, stall/async reset and length-0 / simultaneous push-pop corners.
module tb_vector_write_back_queue;
  import vector_write_back_queue_pkg::*;

  localparam int LEN = 32;
  localparam int VS  = 8;
  localparam int EIS = 3;
  localparam int DEPTH = 4;
  localparam int VW  = VS * LEN;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rdy_in = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [4:0]     in_rd = '0;
  logic           in_vm = 1'b0;
  logic [VW-1:0]  in_mask = '0;
  logic [VW-1:0]  in_data = '0;
  logic [EIS:0]   in_length = '0;
  logic [2:0]     in_data_type = '0;
  logic [1:0]     rf_signal;
  logic [4:0]     rf_rd;
  logic           rf_vm;
  logic [VW-1:0]  rf_mask;
  logic [VW-1:0]  rf_data;
  logic [EIS:0]   rf_length;
  logic [2:0]     rf_data_type;
  logic           write_back_enabled;
  logic [1:0]     rf_status = RF_NOP;
  logic [4:0]     q_rs1 = 5'd31;
  logic [4:0]     q_rs2 = 5'd31;
  logic [4:0]     q_rs3 = 5'd31;
  logic           q_v0 = 1'b0;
  logic           hazard;
  logic           empty;

  int checks = 0;
  int errors = 0;

  vector_write_back_queue #(.LEN(LEN), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_vm(in_vm),
    .in_mask(in_mask), .in_data(in_data), .in_length(in_length), .in_data_type(in_data_type),
    .rf_signal(rf_signal), .rf_rd(rf_rd), .rf_vm(rf_vm), .rf_mask(rf_mask), .rf_data(rf_data),
    .rf_length(rf_length), .rf_data_type(rf_data_type), .write_back_enabled(write_back_enabled),
    .rf_status(rf_status), .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rs3(q_rs3), .q_v0(q_v0),
    .hazard(hazard), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_entry(input logic [4:0] rd, input logic [EIS:0] len, input logic [2:0] dt);
    in_rd        = rd;
    in_vm        = rd[0];
    in_length    = len;
    in_data_type = dt;
    in_data      = {VS{32'hC0DE_0000 | 32'(rd)}};
    in_mask      = {224'd0, 32'hFFFF_0000 | 32'(rd)};
  endtask

  task automatic push(input logic [4:0] rd, input logic [EIS:0] len, input logic [2:0] dt);
    drive_entry(rd, len, dt);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with a request pending
    #2 rst = 1'b0;
    in_valid = 1'b1;
    drive_entry(5'd9, 4'd8, FOUR_BYTE);
    repeat (3) step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_wbe", write_back_enabled, 0);
    chk("rst_signal", rf_signal, RF_NOP);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_hazard", hazard, 0);
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    q_rs1 = 5'd9;
    #1;
    chk("rst_nothing_queued_empty", empty, 1);
    chk("rst_nothing_queued_hazard", hazard, 0);
    chk("rst_nothing_queued_wbe", write_back_enabled, 0);
    q_rs1 = 5'd31;

    // 2: single write
    push(5'd5, 4'd8, FOUR_BYTE);
    chk("t2_empty_after_push", empty, 0);
    chk("t2_no_strobe_yet", write_back_enabled, 0);
    q_rs1 = 5'd5;
    #1 chk("t2_hazard_queued", hazard, 1);
    q_rs1 = 5'd31;
    step();
    chk("t2_strobe", write_back_enabled, 1);
    chk("t2_signal_write", rf_signal, VECTOR_RF_WRITE);
    chk("t2_rf_rd", rf_rd, 5);
    chk("t2_rf_length", rf_length, 8);
    chk("t2_rf_dtype", rf_data_type, FOUR_BYTE);
    chk("t2_rf_vm", rf_vm, 1);
    chk("t2_rf_data", rf_data[63:0], 64'hC0DE0005_C0DE0005);
    chk("t2_rf_mask", rf_mask[31:0], 32'hFFFF0005);
    step();
    chk("t2_strobe_drop", write_back_enabled, 0);
    chk("t2_signal_nop", rf_signal, RF_NOP);
    chk("t2_rd_held", rf_rd, 5);
    rf_status = RF_FINISHED;
    step();
    rf_status = RF_NOP;
    chk("t2_empty_after_finish", empty, 1);

    // 3: fill with the VRF stalled, then drain in order
    in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive_entry(5'(k), 4'd8, EIGHT_BYTE);
      step();
    end
    chk("t3_full_in_ready", in_ready, 0);
    drive_entry(5'd6, 4'd8, EIGHT_BYTE);
    step();
    in_valid = 1'b0;
    chk("t3_first_issued_rd", rf_rd, 1);
    chk("t3_waiting_no_strobe", write_back_enabled, 0);
    chk("t3_still_full", in_ready, 0);
    rf_status = RF_FINISHED;
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("t3_drain_strobe", write_back_enabled, 1);
      chk("t3_drain_rd", rf_rd, 64'(k));
      chk("t3_drain_in_ready", in_ready, 1);
      step();
      chk("t3_drain_gap", write_back_enabled, 0);
    end
    step();
    chk("t3_drained_empty", empty, 1);
    rf_status = RF_NOP;

    // 4: hazard detection
    in_valid = 1'b1;
    drive_entry(5'd3, 4'd4, ONE_BYTE);
    step();
    drive_entry(5'd0, 4'd4, ONE_BYTE);
    step();
    in_valid = 1'b0;
    q_rs2 = 5'd3;
    #1 chk("t4_hazard_rs2_inflight", hazard, 1);
    q_rs2 = 5'd31;
    q_v0 = 1'b1;
    #1 chk("t4_hazard_v0_queued", hazard, 1);
    q_v0 = 1'b0;
    q_rs1 = 5'd7;
    #1 chk("t4_no_hazard", hazard, 0);
    rf_status = RF_FINISHED;
    repeat (4) step();
    rf_status = RF_NOP;
    q_rs2 = 5'd3;
    q_v0 = 1'b1;
    #1 chk("t4_hazard_clear", hazard, 0);
    chk("t4_empty", empty, 1);
    q_rs2 = 5'd31;
    q_v0 = 1'b0;
    drive_entry(5'd9, 4'd4, ONE_BYTE);
    in_valid = 1'b1;
    q_rs1 = 5'd9;
    #1 chk("t4_push_not_hazard", hazard, 0);
    in_valid = 1'b0;
    q_rs1 = 5'd31;

    // 5: stall in WAIT, then async reset mid-WAIT
    push(5'd12, 4'd4, TWO_BYTE);
    step();
    step();
    rdy_in = 1'b0;
    rf_status = RF_FINISHED;
    drive_entry(5'd13, 4'd4, TWO_BYTE);
    in_valid = 1'b1;
    q_rs1 = 5'd12;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_stall_wbe", write_back_enabled, 0);
      chk("t5_stall_rd", rf_rd, 12);
      chk("t5_stall_not_empty", empty, 0);
      chk("t5_stall_hazard", hazard, 1);
    end
    in_valid = 1'b0;
    q_rs1 = 5'd31;
    rdy_in = 1'b1;
    step();
    chk("t5_resume_empty", empty, 1);
    rf_status = RF_NOP;

    in_valid = 1'b1;
    drive_entry(5'd20, 4'd2, FOUR_BYTE);
    step();
    drive_entry(5'd21, 4'd2, FOUR_BYTE);
    step();
    in_valid = 1'b0;
    step();
    chk("t5_wait_rd", rf_rd, 20);
    rst = 1'b0;
    q_rs1 = 5'd21;
    #1;
    chk("t5_async_rd", rf_rd, 0);
    chk("t5_async_length", rf_length, 0);
    chk("t5_async_signal", rf_signal, RF_NOP);
    chk("t5_async_empty", empty, 1);
    chk("t5_async_in_ready", in_ready, 1);
    chk("t5_async_hazard", hazard, 0);
    rst = 1'b1;
    q_rs1 = 5'd31;
    step();
    step();
    chk("t5_post_reset_empty", empty, 1);
    chk("t5_post_reset_wbe", write_back_enabled, 0);

    // 6: length 0 with an unknown data type, then push+pop at count 2
    push(5'd7, 4'd0, 3'd6);
    step();
    chk("t6_len0_strobe", write_back_enabled, 1);
    chk("t6_len0_length", rf_length, 0);
    chk("t6_len0_dtype", rf_data_type, 6);
    chk("t6_len0_rd", rf_rd, 7);
    step();
    step();
    chk("t6_len0_needs_finish", empty, 0);
    rf_status = RF_FINISHED;
    step();
    rf_status = RF_NOP;
    chk("t6_len0_retired", empty, 1);

    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive_entry(5'(k), 4'd8, FOUR_BYTE);
      step();
    end
    chk("t6_count_before", 64'(dut.u_fifo.count_q), 2);
    drive_entry(5'd4, 4'd8, FOUR_BYTE);
    rf_status = RF_FINISHED;
    step();
    in_valid = 1'b0;
    chk("t6_count_after_push_pop", 64'(dut.u_fifo.count_q), 2);
    chk("t6_pop_strobe", write_back_enabled, 1);
    chk("t6_pop_rd", rf_rd, 2);
    for (int k = 3; k <= 4; k++) begin
      step();
      step();
      chk("t6_order_strobe", write_back_enabled, 1);
      chk("t6_order_rd", rf_rd, 64'(k));
    end
    step();
    step();
    chk("t6_final_empty", empty, 1);
    rf_status = RF_NOP;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
